add_alu_core: RTL and testbench
===============================

// Module: add_alu_core
// PURPOSE
//   Registered narrow-width adder stage of the project ALU datapath.
//   Adds the low ADD_W bits of two WIDTH-bit operands modulo 2^ADD_W.
//   Returns the sum zero-extended to WIDTH bits, with carry and zero flags.
//   One-cycle latency; sits between operand mux and ALU result mux.
// PARAMETERS
//   WIDTH  16  operand/result port width in bits
//   ADD_W  3   significant adder width; 1 <= ADD_W <= WIDTH
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operands a/b valid this cycle
//   a          in   WIDTH  operand A (bits above ADD_W ignored)
//   b          in   WIDTH  operand B (bits above ADD_W ignored)
//   out_valid  out  1      g/carry/zero hold a new result this cycle
//   g          out  WIDTH  sum, zero-extended from ADD_W bits
//   carry      out  1      carry out of bit ADD_W-1
//   zero       out  1      1 when g == 0 for the current result
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high: clk, rst.
//   - All outputs are registered; no combinational path from input to output.
//   - Reset: on any rising edge with rst=1, set g=0, carry=0, zero=0, out_valid=0.
//     in_valid in a reset cycle is discarded; rst takes priority over everything.
//   - Compute: on a rising edge with rst=0 and in_valid=1:
//     s[ADD_W:0] = a[ADD_W-1:0] + b[ADD_W-1:0]
//     g <= {WIDTH-ADD_W zeros, s[ADD_W-1:0]}; carry <= s[ADD_W]
//     zero <= (s[ADD_W-1:0] == 0); out_valid <= 1
//   - Idle: on a rising edge with rst=0 and in_valid=0, g/carry/zero hold their
//     last values; out_valid <= 0.
//   - Latency is exactly 1 cycle. Back-to-back in_valid is accepted every cycle
//     with no stall and no backpressure.
//   - Wrap-around: the sum is modulo 2^ADD_W, e.g. ADD_W=3: 7+1 -> g=0,
//     carry=1, zero=1.
//   - Input bits a/b[WIDTH-1:ADD_W] never affect any output.
//   - When ADD_W == WIDTH, g is the full WIDTH-bit sum with no zero padding.
//   - Adder built as an explicit ripple chain of ADD_W full-adder cells in a
//     generate loop; no '+' on the full vectors.
// TESTING
//   (defaults; rst=0 and in_valid=1 unless stated; result checked the edge after)
//   - a=3, b=2 -> g=5, carry=0, zero=0, out_valid=1
//   - a=1, b=6 -> g=7, carry=0, zero=0
//   - rst=1 for 1 cycle with in_valid=1, a=5, b=1 -> g=0, carry=0, zero=0, out_valid=0
//   - release reset, a=2, b=2 -> g=4; then in_valid=0 -> g holds 4, out_valid=0
//   - a=7, b=1 -> g=0, carry=1, zero=1 (3-bit wrap)
//   - a=16'hFFF8, b=16'h0009 -> g=1, carry=0 (upper bits ignored); back-to-back
//     inputs each produce one out_valid pulse

Source files
------------

// File: rtl/add_alu_core.sv
// rtl/add_alu_core.sv - registered narrow-width ripple adder stage with carry/zero flags
module add_alu_core #(
   parameter int WIDTH = 16,
   parameter int ADD_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] g,
   output logic             carry,
   output logic             zero
);

   logic [ADD_W:0]   c;
   logic [ADD_W-1:0] s;
   logic [WIDTH-1:0] sum_ext;

   assign c[0] = 1'b0;

   genvar i;
   generate
      for (i = 0; i < ADD_W; i++) begin : g_fa
         assign s[i]   = a[i] ^ b[i] ^ c[i];
         assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   endgenerate

   // Operand bits above the adder width are deliberately discarded.
   generate
      if (ADD_W < WIDTH) begin : g_pad
         logic unused_hi;
         assign unused_hi = ^{a[WIDTH-1:ADD_W], b[WIDTH-1:ADD_W]};
         assign sum_ext   = {{(WIDTH-ADD_W){1'b0}}, s};
      end else begin : g_full
         assign sum_ext = s;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         g         <= '0;
         carry     <= 1'b0;
         zero      <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            g     <= sum_ext;
            carry <= c[ADD_W];
            zero  <= (s == '0);
         end
      end
   end

endmodule

// File: tb/tb_add_alu_core.sv
// tb/tb_add_alu_core.sv - scoreboard bench for add_alu_core (WIDTH=16, ADD_W=3)
module tb_add_alu_core;

   typedef struct packed {
      logic [15:0] g;
      logic        c;
      logic        z;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        out_valid;
   logic [15:0] g;
   logic        carry;
   logic        zero;

   exp_t exp_q[$];
   exp_t hold;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_pushed = 0;
   int   n_seen = 0;
   logic started = 1'b0;
   logic rst_seen = 1'b0;

   add_alu_core #(.WIDTH(16), .ADD_W(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
      .out_valid(out_valid), .g(g), .carry(carry), .zero(zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      started  <= 1'b1;
      rst_seen <= rst;
   end

   task automatic check(input string name, input logic [17:0] act, input logic [17:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got g/c/z=%h/%b/%b required %h/%b/%b", name,
                  act[17:2], act[1], act[0], req[17:2], req[1], req[0]);
      end
   endtask

   // Monitor: results are popped only when the DUT presents out_valid.
   always @(negedge clk) begin
      if (started) begin
         if (rst_seen) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin
               n_bad++;
               $display("FAIL reset_valid: got out_valid=%b required 0", out_valid);
            end
            check("reset_state", {g, carry, zero}, 18'd0);
            hold = '0;
         end else if (out_valid === 1'b1) begin
            n_seen++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL extra_pulse: got out_valid=1 required 0 (g=%h)", g);
            end else begin
               hold = exp_q.pop_front();
               check("result", {g, carry, zero}, hold);
            end
         end else begin
            check("idle_hold", {g, carry, zero}, hold);
         end
      end
   end

   task automatic step(input logic r, input logic v, input logic [15:0] ta, input logic [15:0] tb,
                       input logic [15:0] eg, input logic ec, input logic ez);
      @(negedge clk);
      rst = r; in_valid = v; a = ta; b = tb;
      if (!r && v) begin
         exp_q.push_back('{g: eg, c: ec, z: ez});
         n_pushed++;
      end
   endtask

   initial begin
      hold = '0;
      step(1, 0, 16'd0, 16'd0, 16'd0, 0, 0);
      step(0, 1, 16'd3, 16'd2, 16'd5, 0, 0);
      step(0, 1, 16'd1, 16'd6, 16'd7, 0, 0);
      step(1, 1, 16'd5, 16'd1, 16'd0, 0, 0);
      step(0, 1, 16'd2, 16'd2, 16'd4, 0, 0);
      step(0, 0, 16'd7, 16'd7, 16'd0, 0, 0);
      step(0, 0, 16'd1, 16'd1, 16'd0, 0, 0);
      step(0, 1, 16'd7, 16'd1, 16'd0, 1, 1);
      step(0, 1, 16'hFFF8, 16'h0009, 16'd1, 0, 0);
      step(0, 1, 16'd6, 16'd7, 16'd5, 1, 0);
      step(0, 1, 16'd4, 16'd4, 16'd0, 1, 1);
      step(0, 1, 16'd0, 16'd0, 16'd0, 0, 1);
      step(0, 1, 16'hABCD, 16'h1234, 16'd1, 1, 0);
      step(0, 0, 16'hFFFF, 16'hFFFF, 16'd0, 0, 0);
      step(0, 0, 16'd0, 16'd0, 16'd0, 0, 0);
      step(0, 0, 16'd0, 16'd0, 16'd0, 0, 0);
      @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0 || n_seen != n_pushed) begin
         n_bad++;
         $display("FAIL pulse_count: got %0d pulses (%0d left queued) required %0d",
                  n_seen, exp_q.size(), n_pushed);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
